// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: opcode values and driver FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_DEC  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_NAND = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } drv_state_t;

endpackage

// File: rtl/alu.sv
// Registered ALU: one-cycle latency from OPCODE/OP1/OP2 to RESULT/CARRY/ZERO.
// CARRY is the carry-out for ADD/INC and the borrow for SUB/DEC; 0 for logic ops.
module alu
  import alu_pkg::*;
#(
  parameter int OPCODE_WIDTH = 2,
  parameter int DATA_WIDTH   = 15
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [OPCODE_WIDTH:0] opcode,
  input  logic [DATA_WIDTH:0]   op1,
  input  logic [DATA_WIDTH:0]   op2,
  output logic [DATA_WIDTH:0]   result,
  output logic                  carry,
  output logic                  zero
);

  logic [DATA_WIDTH+1:0] calc;

  // Combinational operation with one extra bit for carry/borrow
  always_comb begin
    calc = '0;
    case (opcode)
      OP_ADD:  calc = {1'b0, op1} + {1'b0, op2};
      OP_SUB:  calc = {1'b0, op1} - {1'b0, op2};
      OP_INC:  calc = {1'b0, op1} + (DATA_WIDTH+2)'(1);
      OP_DEC:  calc = {1'b0, op1} - (DATA_WIDTH+2)'(1);
      OP_AND:  calc = {1'b0, op1 & op2};
      OP_OR:   calc = {1'b0, op1 | op2};
      OP_NAND: calc = {1'b0, ~(op1 & op2)};
      OP_XOR:  calc = {1'b0, op1 ^ op2};
      default: calc = '0;
    endcase
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rstn) begin
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
    end else begin
      result <= calc[DATA_WIDTH:0];
      carry  <= calc[DATA_WIDTH+1];
      zero   <= (calc[DATA_WIDTH:0] == '0);
    end
  end

endmodule

// File: rtl/alu_cmd_fifo.sv
// Small synchronous FIFO for queued ALU commands. The head is read
// combinationally so the driver can load and pop on the same edge.
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_driver.sv
// Command-side initiator for the registered ALU: buffers requests, issues one
// at a time, captures result/flags one cycle after issue, returns them with tag.
module alu_driver
  import alu_pkg::*;
#(
  parameter int OPCODE_WIDTH = 2,
  parameter int DATA_WIDTH   = 15,
  parameter int TAG_WIDTH    = 3,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OPCODE_WIDTH:0] cmd_opcode,
  input  logic [DATA_WIDTH:0]   cmd_op1,
  input  logic [DATA_WIDTH:0]   cmd_op2,
  input  logic [TAG_WIDTH:0]    cmd_tag,
  output logic [OPCODE_WIDTH:0] alu_opcode,
  output logic [DATA_WIDTH:0]   alu_op1,
  output logic [DATA_WIDTH:0]   alu_op2,
  input  logic [DATA_WIDTH:0]   alu_result,
  input  logic                  alu_carry,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH:0]   rsp_result,
  output logic                  rsp_carry,
  output logic                  rsp_zero,
  output logic [TAG_WIDTH:0]    rsp_tag,
  output logic                  busy
);

  localparam int ENTRY_W = (TAG_WIDTH + 1) + (OPCODE_WIDTH + 1) + 2 * (DATA_WIDTH + 1);

  drv_state_t            state;
  logic [TAG_WIDTH:0]    tag_reg;
  logic [ENTRY_W-1:0]    fifo_din;
  logic [ENTRY_W-1:0]    fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  load;
  logic [TAG_WIDTH:0]    head_tag;
  logic [OPCODE_WIDTH:0] head_opcode;
  logic [DATA_WIDTH:0]   head_op1;
  logic [DATA_WIDTH:0]   head_op2;

  assign fifo_din = {cmd_tag, cmd_opcode, cmd_op1, cmd_op2};
  assign {head_tag, head_opcode, head_op1, head_op2} = fifo_dout;

  // Full comes from the registered count, so a same-cycle pop never frees a slot early
  assign cmd_ready = !rst && !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  // Head is taken from IDLE, or from RESP once the current response is consumed
  assign load      = !fifo_empty && ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  alu_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (load),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Issue/capture/respond sequencing; alu_* only change on a load
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tag_reg    <= '0;
      alu_opcode <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_tag    <= '0;
    end else begin
      if (load) begin
        alu_opcode <= head_opcode;
        alu_op1    <= head_op1;
        alu_op2    <= head_op2;
        tag_reg    <= head_tag;
      end
      case (state)
        ST_IDLE: begin
          if (load) state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          rsp_result <= alu_result;
          rsp_carry  <= alu_carry;
          rsp_zero   <= alu_zero;
          rsp_tag    <= tag_reg;
          rsp_valid  <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= load ? ST_ISSUE : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
